// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared sizes, FSM state codes and grant codes for the miss
//            refill arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

   localparam int WORDS  = 128;
   localparam int OFF_W  = 7;
   localparam int LINE_W = WORDS * 32;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_FILL = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic GNT_I = 1'b0;
   localparam logic GNT_D = 1'b1;

   // Block-aligned upper address bits of a miss address.
   function automatic logic [31-OFF_W-2:0] block_of(input logic [31:0] addr);
      return addr[31:OFF_W+2];
   endfunction

endpackage
`default_nettype wire

// File: rtl/miss_refill_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Combinational 2-way round-robin arbiter; bit 0 = icache,
//            bit 1 = dcache. The last-grant state is held by the parent.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
   import mem_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic [1:0] o_gnt
);

   always_comb begin
      o_gnt = 2'b00;
      case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         // On a tie the side that was not served last wins.
         2'b11:   o_gnt = (i_last == GNT_D) ? 2'b01 : 2'b10;
         default: o_gnt = 2'b00;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/miss_refill_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : miss_refill_arbiter
// Purpose  : Shares one 32-bit memory read port between icache and dcache
//            miss paths, assembling a full block before pulsing ready.
// Revision : 1.0 - initial release
// ============================================================================
module miss_refill_arbiter
   import mem_pkg::*;
(
   input  logic              Clk,
   input  logic              Rst,
   input  logic              i_miss,
   input  logic [31:0]       i_addr,
   input  logic              i_abort,
   output logic              i_ready,
   input  logic              d_miss,
   input  logic [31:0]       d_addr,
   output logic              d_ready,
   output logic [LINE_W-1:0] line_out,
   output logic              mem_req,
   output logic [31:0]       mem_addr,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata
);

   logic [1:0]          r_state;
   logic [OFF_W-1:0]    r_cnt;
   logic [31-OFF_W-2:0] r_base;
   logic                r_gnt_d;
   logic                r_last;
   logic                r_mem_req;
   logic                r_i_ready;
   logic                r_d_ready;

   logic [1:0]          w_gnt;
   logic [31:0]         w_req_addr;
   logic                w_abort;
   logic                w_wr;
   logic                w_last_word;
   logic [WORDS-1:0]    w_we;
   logic                w_unused;

   rr_arb2 u_arb (
      .i_req  ({d_miss, i_miss}),
      .i_last (r_last),
      .o_gnt  (w_gnt)
   );

   assign w_req_addr  = w_gnt[1] ? d_addr : i_addr;
   assign w_unused    = ^w_req_addr[OFF_W+1:0];
   assign w_abort     = (r_state == S_FILL) && (r_gnt_d == GNT_I) && i_abort;
   assign w_wr        = (r_state == S_FILL) && mem_ack && !w_abort;
   assign w_last_word = (r_cnt == OFF_W'(WORDS - 1));
   assign w_we        = w_wr ? (WORDS'(1) << r_cnt) : '0;

   assign mem_req  = r_mem_req;
   assign mem_addr = {r_base, r_cnt, 2'b00};
   assign i_ready  = r_i_ready;
   assign d_ready  = r_d_ready;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_base    <= '0;
         r_gnt_d   <= GNT_I;
         r_last    <= GNT_D;
         r_mem_req <= 1'b0;
         r_i_ready <= 1'b0;
         r_d_ready <= 1'b0;
      end else begin
         r_i_ready <= 1'b0;
         r_d_ready <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (|w_gnt) begin
                  r_gnt_d   <= w_gnt[1] ? GNT_D : GNT_I;
                  r_base    <= block_of(w_req_addr);
                  r_cnt     <= '0;
                  r_mem_req <= 1'b1;
                  r_state   <= S_FILL;
               end
            end
            S_FILL: begin
               if (w_abort) begin
                  r_cnt     <= '0;
                  r_mem_req <= 1'b0;
                  r_state   <= S_IDLE;
               end else if (mem_ack) begin
                  r_cnt <= r_cnt + OFF_W'(1);
                  if (w_last_word) begin
                     r_mem_req <= 1'b0;
                     r_i_ready <= (r_gnt_d == GNT_I);
                     r_d_ready <= (r_gnt_d == GNT_D);
                     r_state   <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               // Fairness pointer moves only on a completed fill.
               r_last  <= r_gnt_d;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   for (genvar k = 0; k < WORDS; k++) begin : g_word
      logic [31:0] r_word;
      always_ff @(posedge Clk or posedge Rst) begin
         if (Rst)
            r_word <= '0;
         else if (w_we[k])
            r_word <= mem_rdata;
      end
      assign line_out[32*k +: 32] = r_word;
   end

endmodule
`default_nettype wire

// File: tb/tb_miss_refill_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_miss_refill_arbiter
// Purpose  : Self-checking bench for miss_refill_arbiter with a block-level
//            reference model of grants, addresses and line contents.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_miss_refill_arbiter;
   import mem_pkg::*;

   logic              Clk = 1'b0;
   logic              Rst = 1'b0;
   logic              i_miss = 1'b0, i_abort = 1'b0, d_miss = 1'b0;
   logic [31:0]       i_addr = '0, d_addr = '0;
   logic              i_ready, d_ready, mem_req;
   logic [LINE_W-1:0] line_out;
   logic [31:0]       mem_addr;
   logic              mem_ack = 1'b0;
   logic [31:0]       mem_rdata = '0;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] exp_line [WORDS];
   logic        exp_last_d;
   logic [31:0] salt;

   miss_refill_arbiter dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .i_miss    (i_miss),
      .i_addr    (i_addr),
      .i_abort   (i_abort),
      .i_ready   (i_ready),
      .d_miss    (d_miss),
      .d_addr    (d_addr),
      .d_ready   (d_ready),
      .line_out  (line_out),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_line(input string tag);
      logic [LINE_W-1:0] e;
      int bad;
      bad = 0;
      for (int k = 0; k < WORDS; k++) e[32*k +: 32] = exp_line[k];
      for (int k = WORDS - 1; k >= 0; k--)
         if (line_out[32*k +: 32] !== exp_line[k]) bad = k;
      vectors++;
      assert (line_out === e) else begin
         miscompares++;
         $error("FAIL %s: word %0d observed %h expected %h",
                tag, bad, line_out[32*bad +: 32], exp_line[bad]);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   function automatic logic pick_d(input logic im, input logic dm);
      if (im && dm) return !exp_last_d;
      return dm;
   endfunction

   // Plays memory for one granted fill, starting in the first FILL cycle.
   // mode 0: ack every cycle, 1: ack on alternate cycles, 2: random acks.
   task automatic serve(input string who, input logic src_d, input logic [31:0] addr,
                        input int mode, input int abort_at, input int stop_at,
                        output int cycles, output bit aborted);
      logic [31:0] base;
      logic [31:0] data;
      bit          ack;
      int          k;
      base    = {addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
      k       = 0;
      cycles  = 0;
      aborted = 1'b0;
      while (k < WORDS) begin
         if (cycles > 8 * WORDS) begin
            chk({who, " timeout words"}, k, WORDS);
            mem_ack = 1'b0;
            return;
         end
         chk({who, " mem_req"}, 32'(mem_req), 32'd1);
         chk({who, " mem_addr"}, mem_addr, base + 32'(4 * k));
         chk({who, " ready during fill"}, {30'd0, i_ready, d_ready}, 32'd0);
         if (k == stop_at) return;
         case (mode)
            0:       ack = 1'b1;
            1:       ack = cycles[0];
            default: ack = ($urandom_range(0, 2) != 0);
         endcase
         data      = (base + 32'(4 * k)) ^ salt;
         mem_ack   = ack;
         mem_rdata = ack ? data : $urandom;
         i_abort   = (k == abort_at) && ack;
         step();
         cycles++;
         if (i_abort && !src_d) begin
            i_abort = 1'b0;
            mem_ack = 1'b0;
            aborted = 1'b1;
            chk({who, " mem_req after abort"}, 32'(mem_req), 32'd0);
            chk({who, " i_ready after abort"}, 32'(i_ready), 32'd0);
            chk_line({who, " line after abort"});
            return;
         end
         i_abort = 1'b0;
         if (ack) begin
            exp_line[k] = data;
            k++;
         end
      end
      mem_ack = 1'b0;
      chk({who, " ready pulse"}, {30'd0, i_ready, d_ready}, src_d ? 32'd1 : 32'd2);
      chk({who, " mem_req done"}, 32'(mem_req), 32'd0);
      chk_line({who, " line"});
      exp_last_d = src_d;
      step();
      chk({who, " ready one cycle"}, {30'd0, i_ready, d_ready}, 32'd0);
   endtask

   initial begin
      int cyc;
      bit ab;
      logic w;
      int ab_at;
      for (int k = 0; k < WORDS; k++) exp_line[k] = '0;
      exp_last_d = 1'b1;
      salt = '0;

      #2 Rst = 1'b1;
      #2;
      chk("reset mem_req", 32'(mem_req), 32'd0);
      chk("reset mem_addr", mem_addr, 32'd0);
      chk("reset ready", {30'd0, i_ready, d_ready}, 32'd0);
      chk_line("reset line");
      step();
      step();
      Rst = 1'b0;
      step();

      // Single icache fill with data equal to word address.
      i_miss = 1'b1;
      i_addr = 32'h0000_1234;
      step();
      serve("t1", 1'b0, i_addr, 0, -1, -1, cyc, ab);
      i_miss = 1'b0;
      chk("t1 ready latency", 32'(cyc + 1), 32'(WORDS + 1));
      chk("t1 word5", line_out[5*32 +: 32], 32'h0000_1214);

      // Simultaneous requests, twice: round-robin alternates.
      for (int rep = 0; rep < 2; rep++) begin
         i_addr = $urandom;
         d_addr = i_addr ^ 32'h4000_0000;
         salt   = $urandom;
         i_miss = 1'b1;
         d_miss = 1'b1;
         while (i_miss || d_miss) begin
            w = pick_d(i_miss, d_miss);
            step();
            serve(w ? "tie d" : "tie i", w, w ? d_addr : i_addr, 0, -1, -1, cyc, ab);
            if (w) d_miss = 1'b0; else i_miss = 1'b0;
         end
      end

      // Alternate-cycle acks: twice as many FILL cycles.
      d_addr = $urandom;
      salt   = $urandom;
      d_miss = 1'b1;
      step();
      serve("t3", 1'b1, d_addr, 1, -1, -1, cyc, ab);
      d_miss = 1'b0;
      chk("t3 fill cycles", 32'(cyc), 32'(2 * WORDS));

      // Icache abort at word 40 with a dcache miss waiting.
      i_addr = $urandom;
      d_addr = i_addr ^ 32'h0010_0000;
      salt   = $urandom;
      i_miss = 1'b1;
      step();
      d_miss = 1'b1;
      serve("t4 i", 1'b0, i_addr, 0, 40, -1, cyc, ab);
      chk("t4 aborted", 32'(ab), 32'd1);
      i_miss = 1'b0;
      step();
      serve("t4 d", 1'b1, d_addr, 0, -1, -1, cyc, ab);
      d_miss = 1'b0;

      // Abort during a dcache fill is ignored.
      d_addr = $urandom;
      salt   = $urandom;
      d_miss = 1'b1;
      step();
      serve("t5", 1'b1, d_addr, 0, 30, -1, cyc, ab);
      d_miss = 1'b0;

      // Asynchronous reset in the middle of an icache fill.
      i_addr = $urandom;
      salt   = $urandom;
      i_miss = 1'b1;
      step();
      serve("t6", 1'b0, i_addr, 0, -1, 60, cyc, ab);
      mem_ack = 1'b0;
      i_miss  = 1'b0;
      #1 Rst  = 1'b1;
      #1;
      for (int k = 0; k < WORDS; k++) exp_line[k] = '0;
      exp_last_d = 1'b1;
      chk("t6 rst mem_req", 32'(mem_req), 32'd0);
      chk("t6 rst mem_addr", mem_addr, 32'd0);
      chk("t6 rst ready", {30'd0, i_ready, d_ready}, 32'd0);
      chk_line("t6 rst line");
      step();
      Rst = 1'b0;
      step();
      i_addr = $urandom;
      d_addr = i_addr ^ 32'h0800_0000;
      i_miss = 1'b1;
      d_miss = 1'b1;
      while (i_miss || d_miss) begin
         w = pick_d(i_miss, d_miss);
         step();
         serve(w ? "t6 d" : "t6 i", w, w ? d_addr : i_addr, 0, -1, -1, cyc, ab);
         if (w) d_miss = 1'b0; else i_miss = 1'b0;
      end

      // Randomized traffic: random requesters, wait states and aborts.
      for (int n = 0; n < 6; n++) begin
         int pat;
         pat    = $urandom_range(1, 3);
         i_addr = $urandom;
         d_addr = $urandom ^ 32'h2000_0000;
         salt   = $urandom;
         i_miss = pat[0];
         d_miss = pat[1];
         while (i_miss || d_miss) begin
            w     = pick_d(i_miss, d_miss);
            ab_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, WORDS - 1)) : -1;
            step();
            serve(w ? "rnd d" : "rnd i", w, w ? d_addr : i_addr, 2, ab_at, -1, cyc, ab);
            if (w) d_miss = 1'b0; else i_miss = 1'b0;
         end
      end

      step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
